mem_test_seq: RTL
=================

// Module: mem_test_seq
// PURPOSE
//  Parametrised self-checking traffic sequencer for the cache/memory subsystem.
//  On start, it runs a write pass then a read-back pass over NVEC generated addresses.
//  It drives the cache request port, compares read data against the expected pattern,
//  and counts hits, misses and mismatches. It sits between board switches/debug logic
//  and the cache, and is the bring-up harness for any cache geometry.
// PARAMETERS
//  AW        8     cache address width
//  DW        8     cache data width
//  NVEC      8     vectors per pass, 1..2**AW; index width IW=$clog2(NVEC+1)
//  CW        16    width of hit/miss/error counters
//  DATA_SEED 8'hA5 XOR seed for the data pattern (resized to DW)
//  TIMEOUT   64    max cycles a request may wait for cache_ack
// PORTS
//  clk            in   1   system clock, all logic on posedge
//  clr            in   1   asynchronous active-low reset
//  start          in   1   level; sampled only in IDLE/DONE, begins a run
//  mode           in   2   00 walk-ones, 01 incrementing, 10 incr-write/descend-read, 11 read-only
//  abort          in   1   synchronous stop, any state -> DONE
//  cache_enab     out  1   request valid to cache
//  cache_rw       out  1   1=write 0=read, valid with cache_enab
//  cache_addr     out  AW  request address
//  cache_wdata    out  DW  write data
//  cache_ack      in   1   one-cycle completion pulse from cache
//  cache_rdata    in   DW  read data, valid with cache_ack on reads
//  cache_hit      in   1   hit flag, valid with cache_ack
//  busy           out  1   run in progress
//  done           out  1   run finished, held until next start or reset
//  pass           out  1   valid when done: err_count==0, no timeout, no abort
//  timeout        out  1   sticky, set when a request exceeds TIMEOUT cycles
//  vec_idx        out  IW  current vector index
//  hit_count      out  CW  acks with cache_hit=1, saturating
//  miss_count     out  CW  acks with cache_hit=0, saturating
//  err_count      out  CW  read mismatches, saturating
//  first_err_addr out  AW  address of first mismatch, 0 if none
// BEHAVIOUR
//  Reset (clr=0, async): state IDLE. All outputs 0, all counters 0, cache_addr/wdata 0.
//  Addr gen, index k: mode00 addr=1<<(k mod AW). mode01/11 addr=k. mode10: write addr=k,
//   read addr=NVEC-1-k. Results are truncated to AW.
//  Data: pattern(addr) = resize(addr, DW) ^ resize(DATA_SEED, DW). Zero-extend or truncate.
//   The pattern depends on the address, so repeated addresses (mode00 with NVEC>AW) stay consistent.
//  FSM states: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE.
//  IDLE/DONE + start=1: latch mode, clear counters, first_err_addr, timeout, done, pass;
//   set vec_idx=0, busy=1. Next state is WR_REQ, or RD_REQ if mode==11.
//  WR_REQ: cache_enab=1, rw=1, addr/wdata are stable until cache_ack.
//   On ack: if vec_idx==NVEC-1, set vec_idx=0 -> RD_GAP; else vec_idx++ -> WR_GAP.
//  *_GAP: cache_enab=0 for exactly one cycle, then *_REQ with the new index.
//  RD_REQ: cache_enab=1, rw=0. On ack: compare rdata vs pattern(addr).
//   On mismatch: err_count++; if err_count was 0, capture first_err_addr.
//   If last index -> DONE, else vec_idx++ -> RD_GAP.
//  Mode 11: compare is suppressed, only hit/miss counts.
//  Every ack, read or write, increments hit_count or miss_count per cache_hit.
//  Each request counts acks only while cache_enab=1. An ack in a GAP/IDLE/DONE state is ignored.
//  Wait counter: resets on each new request. Reaching TIMEOUT without ack sets timeout -> DONE.
//  DONE: busy=0, done=1, cache_enab=0. pass=(err_count==0)&&!timeout&&!aborted.
//  abort: highest priority after reset. Any state -> DONE next cycle with pass=0.
//   Counters freeze. An ack in the same cycle as abort is not counted.
//  Saturating counters stop at all-ones, no wrap.
//  start held high in DONE immediately restarts. No latency beyond the one-cycle gaps.
// TESTING
//  1 Reset: clr low mid-WR_REQ -> all outputs 0 async, next start runs from vec_idx=0.
//  2 mode01, ideal cache (ack 1 cycle, rdata correct, hit=1 on reads) -> done, pass=1,
//    hit_count=8, miss_count=8 (writes miss), err_count=0, 32 cycles start->done.
//  3 Fault: cache returns rdata bit0 flipped at addr 3 only (mode01) ->
//    err_count=1, first_err_addr=8'h03, pass=0.
//  4 mode00, NVEC=12: addresses 01,02,..,80,01,02,04,08, read data 01^A5=A4 etc., pass=1.
//  5 Cache never acks -> timeout=1 at 64 cycles after the request, done=1, pass=0, counts 0.
//  6 abort in RD_REQ with ack the same cycle -> DONE next cycle, ack uncounted, pass=0;
//    also CW=4 with 20 misses -> miss_count=4'hF.

Source files
------------

// File: rtl/mem_test_seq.sv
// mem_test_seq: self-checking traffic sequencer for cache/memory bring-up.
//   When started it makes a write pass and then a read-back pass over NVEC
//   generated addresses. Read data is checked against an address-derived
//   pattern. Hits, misses and mismatches are counted with saturating counters.
// Ports:
//   clk, clr (async active-low reset)
//   start, mode[1:0], abort                : run control from switches/debug
//   cache_enab/rw/addr/wdata               : request to the cache
//   cache_ack/rdata/hit                    : completion from the cache
//   busy, done, pass, timeout, vec_idx     : run status
//   hit_count, miss_count, err_count,
//   first_err_addr                         : results
module mem_test_seq #(
  parameter int          AW        = 8,
  parameter int          DW        = 8,
  parameter int          NVEC      = 8,
  parameter int          CW        = 16,
  parameter logic [7:0]  DATA_SEED = 8'hA5,
  parameter int          TIMEOUT   = 64,
  parameter int          IW        = $clog2(NVEC + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic          abort,
  output logic          cache_enab,
  output logic          cache_rw,
  output logic [AW-1:0] cache_addr,
  output logic [DW-1:0] cache_wdata,
  input  logic          cache_ack,
  input  logic [DW-1:0] cache_rdata,
  input  logic          cache_hit,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [IW-1:0] vec_idx,
  output logic [CW-1:0] hit_count,
  output logic [CW-1:0] miss_count,
  output logic [CW-1:0] err_count,
  output logic [AW-1:0] first_err_addr
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WR_REQ = 3'd1;
  localparam logic [2:0] WR_GAP = 3'd2;
  localparam logic [2:0] RD_REQ = 3'd3;
  localparam logic [2:0] RD_GAP = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    state;
  logic [1:0]    mode_q;
  logic          aborted;
  logic [TW-1:0] wait_cnt;
  logic [31:0]   k32;
  logic [AW-1:0] gen_addr;
  logic [DW-1:0] addr_dw, seed_w, pattern;
  logic          last, mismatch;

  // Address for the current index. Mode 10 walks reads downwards, so the
  // address depends on which pass is active, not only on the index.
  always_comb begin
    k32      = 32'(vec_idx);
    gen_addr = AW'(k32);
    case (mode_q)
      2'b00:   gen_addr = AW'(1) << (k32 % AW);
      2'b10:   gen_addr = (state == RD_REQ) ? AW'(32'(NVEC - 1) - k32) : AW'(k32);
      default: gen_addr = AW'(k32);
    endcase
  end

  // Zero-extend or truncate address and seed to the data width.
  for (genvar i = 0; i < DW; i++) begin : g_rs
    if (i < AW) begin : g_a
      assign addr_dw[i] = gen_addr[i];
    end else begin : g_az
      assign addr_dw[i] = 1'b0;
    end
    if (i < 8) begin : g_s
      assign seed_w[i] = DATA_SEED[i];
    end else begin : g_sz
      assign seed_w[i] = 1'b0;
    end
  end

  assign pattern  = addr_dw ^ seed_w;
  assign last     = (vec_idx == IW'(NVEC - 1));
  assign mismatch = (mode_q != 2'b11) && (cache_rdata != pattern);

  assign cache_enab  = (state == WR_REQ) || (state == RD_REQ);
  assign cache_rw    = (state == WR_REQ);
  assign cache_addr  = cache_enab ? gen_addr : '0;
  assign cache_wdata = cache_rw ? pattern : '0;
  assign busy        = (state == WR_REQ) || (state == WR_GAP) ||
                       (state == RD_REQ) || (state == RD_GAP);
  assign done        = (state == DONE);
  assign pass        = done && (err_count == '0) && !timeout && !aborted;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state          <= IDLE;
      mode_q         <= '0;
      aborted        <= 1'b0;
      wait_cnt       <= '0;
      vec_idx        <= '0;
      hit_count      <= '0;
      miss_count     <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      timeout        <= 1'b0;
    end else if (abort) begin
      // Counters freeze; an ack arriving with abort is dropped.
      state   <= DONE;
      aborted <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mode_q         <= mode;
            aborted        <= 1'b0;
            wait_cnt       <= '0;
            vec_idx        <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
            state          <= (mode == 2'b11) ? RD_REQ : WR_REQ;
          end
        end
        WR_REQ, RD_REQ: begin
          if (cache_ack) begin
            wait_cnt <= '0;
            if (cache_hit) begin
              if (hit_count != '1) hit_count <= hit_count + CW'(1);
            end else begin
              if (miss_count != '1) miss_count <= miss_count + CW'(1);
            end
            if (state == WR_REQ) begin
              if (last) begin
                vec_idx <= '0;
                state   <= RD_GAP;
              end else begin
                vec_idx <= vec_idx + IW'(1);
                state   <= WR_GAP;
              end
            end else begin
              if (mismatch) begin
                if (err_count != '1) err_count <= err_count + CW'(1);
                if (err_count == '0) first_err_addr <= gen_addr;
              end
              if (last) begin
                state <= DONE;
              end else begin
                vec_idx <= vec_idx + IW'(1);
                state   <= RD_GAP;
              end
            end
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        WR_GAP:  state <= WR_REQ;
        RD_GAP:  state <= RD_REQ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
